// File: rtl/operand_tf_pkg.sv
// Shared types for the operand-transformer block: warp payloads, results, scheduler states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package operand_tf_pkg;

    localparam int WARP_SIZE      = 32;
    localparam int NUM_LANES      = 16;
    localparam int ELEM_WIDTH_IN  = 8;
    localparam int ELEM_WIDTH_OUT = 16;
    localparam int NUM_SCALES     = 16;
    localparam int SCALE_WIDTH    = 8;

    // Two half-warp beats carry one warp through the 16-lane transformer.
    localparam int BEATS_PER_WARP = WARP_SIZE / NUM_LANES;

    localparam int LANE_W      = $clog2(NUM_LANES);
    localparam int ELEM_IDX_W  = $clog2(WARP_SIZE);
    localparam int SCALE_IDX_W = $clog2(NUM_SCALES);

    typedef struct packed {
        logic scale_sharing_mode;   // 0: one scale per 2 elements, 1: one scale per 4 elements
    } operand_cfg_t;

    typedef struct packed {
        operand_cfg_t                                cfg;
        logic [NUM_SCALES-1:0][SCALE_WIDTH-1:0]      micro_scales;
        logic [WARP_SIZE-1:0][ELEM_WIDTH_IN-1:0]     elements;
    } operand_input_t;

    typedef struct packed {
        logic [WARP_SIZE-1:0][ELEM_WIDTH_OUT-1:0]    elements;
    } operand_output_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        ISSUE1 = 3'd2,
        DRAIN  = 3'd3,
        RESP   = 3'd4
    } sched_state_e;

endpackage

// File: rtl/operand_tf_rr_arb.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module operand_tf_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TAG_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [TAG_W-1:0]   id
);

    logic [TAG_W:0] cand;
    logic           found;

    // Scan candidates starting at ptr; the first valid one wins.
    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (TAG_W+1)'(i);
            // ptr < NUM_REQ and i < NUM_REQ, so a single subtract wraps it.
            if (cand >= (TAG_W+1)'(NUM_REQ)) begin
                cand = cand - (TAG_W+1)'(NUM_REQ);
            end
            if (!found && req[cand[TAG_W-1:0]]) begin
                found                = 1'b1;
                gnt[cand[TAG_W-1:0]] = 1'b1;
                id                   = cand[TAG_W-1:0];
            end
        end
    end

endmodule

// File: rtl/operand_tf_sched.sv
// Round-robin scheduler that pushes whole warps through the shared 16-lane transformer as two beats and reassembles the result.
// Latency: 1 accept + 2 issue + transformer latency + 1 response cycle minimum; one warp in flight.
// Backpressure: tf_ready stalls issue, rsp_ready holds the response; req_ready only in IDLE. Perf counters need OPERAND_TF_SCHED_PERF_EN.
module operand_tf_sched
    import operand_tf_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  operand_input_t [NUM_REQ-1:0]              req_data,
    output logic                                      tf_valid,
    input  logic                                      tf_ready,
    output logic                                      tf_beat,
    output logic [NUM_LANES-1:0][ELEM_WIDTH_IN-1:0]   tf_elems,
    output logic [NUM_LANES-1:0][SCALE_WIDTH-1:0]     tf_scales,
    input  logic                                      tf_out_valid,
    input  logic [NUM_LANES-1:0][ELEM_WIDTH_OUT-1:0]  tf_out_elems,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output operand_output_t                           rsp_data,
    output logic [TAG_W-1:0]                          rsp_id,
    output logic                                      busy,
    output logic                                      err_sticky,
    output logic [31:0]                               perf_warps,
    output logic [31:0]                               perf_stall
);

    sched_state_e     state_q,   state_d;
    logic [TAG_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic [TAG_W-1:0] tag_q,     tag_d;
    operand_input_t   payload_q, payload_d;
    operand_output_t  result_q,  result_d;
    logic [1:0]       rx_cnt_q,  rx_cnt_d;
    logic             err_q,     err_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [TAG_W-1:0]   arb_id;
    logic               rx_window;
    logic               rsp_hs;

    logic [ELEM_IDX_W-1:0]  elem_idx;
    logic [SCALE_IDX_W-1:0] scale_idx;

    operand_tf_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .id  (arb_id)
    );

    // Warp sequencing FSM plus result collection, which runs independently of issue progress.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        tag_d     = tag_q;
        payload_d = payload_q;
        result_d  = result_q;
        rx_cnt_d  = rx_cnt_q;
        err_d     = err_q;
        req_ready = '0;
        tf_valid  = 1'b0;
        tf_beat   = 1'b0;
        rsp_valid = 1'b0;
        rsp_hs    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = arb_gnt;
                if (|arb_gnt) begin
                    payload_d = req_data[arb_id];
                    tag_d     = arb_id;
                    rr_ptr_d  = (arb_id == TAG_W'(NUM_REQ-1)) ? '0 : arb_id + TAG_W'(1);
                    state_d   = ISSUE0;
                end
            end
            ISSUE0: begin
                tf_valid = 1'b1;
                if (tf_ready) begin
                    state_d = ISSUE1;
                end
            end
            ISSUE1: begin
                tf_valid = 1'b1;
                tf_beat  = 1'b1;
                if (tf_ready) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rx_cnt_q == 2'(BEATS_PER_WARP)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Beats come back in issue order, so rx_cnt alone picks the half-warp slot.
        rx_window = (state_q == ISSUE0) || (state_q == ISSUE1) || (state_q == DRAIN);
        if (tf_out_valid) begin
            if (rx_window && (rx_cnt_q != 2'(BEATS_PER_WARP))) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    result_d.elements[{rx_cnt_q[0], LANE_W'(l)}] = tf_out_elems[l];
                end
                rx_cnt_d = rx_cnt_q + 2'd1;
            end else begin
                // Nothing is expecting a beat: drop it and flag the protocol error.
                err_d = 1'b1;
            end
        end
        if (rsp_hs) begin
            rx_cnt_d = '0;
        end
    end

    // Lane element and micro-scale selection for the beat being issued; zero when idle.
    always_comb begin
        tf_elems  = '0;
        tf_scales = '0;
        elem_idx  = '0;
        scale_idx = '0;
        if (tf_valid) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                elem_idx    = {tf_beat, LANE_W'(l)};
                tf_elems[l] = payload_q.elements[elem_idx];
                if (payload_q.cfg.scale_sharing_mode) begin
                    scale_idx = {1'b0, elem_idx[ELEM_IDX_W-1:2]};
                end else begin
                    scale_idx = elem_idx[ELEM_IDX_W-1:1];
                end
                tf_scales[l] = payload_q.micro_scales[scale_idx];
            end
        end
    end

    // State, payload, result and error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            tag_q     <= '0;
            payload_q <= '0;
            result_q  <= '0;
            rx_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            tag_q     <= tag_d;
            payload_q <= payload_d;
            result_q  <= result_d;
            rx_cnt_q  <= rx_cnt_d;
            err_q     <= err_d;
        end
    end

    assign rsp_data   = result_q;
    assign rsp_id     = tag_q;
    assign busy       = (state_q != IDLE);
    assign err_sticky = err_q;

`ifdef OPERAND_TF_SCHED_PERF_EN
    logic [31:0] perf_warps_q, perf_warps_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating completion and stall counters.
    always_comb begin
        perf_warps_d = perf_warps_q;
        perf_stall_d = perf_stall_q;
        if (rsp_hs && (perf_warps_q != 32'hFFFF_FFFF)) begin
            perf_warps_d = perf_warps_q + 32'd1;
        end
        if (tf_valid && !tf_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_warps_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_warps_q <= perf_warps_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_warps = perf_warps_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_warps = '0;
    assign perf_stall = '0;
`endif

endmodule
